// File: rtl/multdiv32.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide; 33 cycles from start to result.
module multdiv32 (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        mthi,
   input  logic        mtlo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic        is_div, neg_res, neg_rem, div_zero;
   logic [31:0] acc_hi, acc_lo, opnd;

   // op[0] clear selects the signed variants (MULT, DIV)
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   assign a_neg = ~op[0] & operand_a[31];
   assign b_neg = ~op[0] & operand_b[31];
   assign a_mag = a_neg ? (~operand_a + 32'd1) : operand_a;
   assign b_mag = b_neg ? (~operand_b + 32'd1) : operand_b;

   logic [32:0] add_sum;
   logic [32:0] div_shift;
   logic [31:0] div_sub;
   logic        borrow;
   assign add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
   assign div_shift = {acc_hi, acc_lo[31]};
   // The partial remainder stays below the divisor, so the kept difference fits in 32 bits
   assign borrow    = div_shift < {1'b0, opnd};
   assign div_sub   = div_shift[31:0] - opnd;

   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix, res_hi, res_lo;
   assign prod_fix = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
   // A zero divisor leaves all-ones quotient and |dividend| remainder; skip quotient negation
   assign quo_fix  = (neg_res & ~div_zero) ? (~acc_lo + 32'd1) : acc_lo;
   assign rem_fix  = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
   assign res_hi   = is_div ? rem_fix : prod_fix[63:32];
   assign res_lo   = is_div ? quo_fix : prod_fix[31:0];

   // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (count == 5'd31) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         count    <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= (operand_b == 32'd0);
                  count    <= '0;
                  acc_hi   <= '0;
                  acc_lo   <= op[1] ? a_mag : b_mag;
                  opnd     <= op[1] ? b_mag : a_mag;
               end else begin
                  if (mthi) hi <= operand_a;
                  if (mtlo) lo <= operand_a;
               end
            end
            CALC: begin
               count <= count + 5'd1;
               if (is_div) begin
                  acc_hi <= borrow ? div_shift[31:0] : div_sub;
                  acc_lo <= {acc_lo[30:0], ~borrow};
               end else begin
                  {acc_hi, acc_lo} <= {add_sum, acc_lo[31:1]};
               end
            end
            FINISH: begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv32.sv
// Self-checking bench for multdiv32: transaction-level reference model compared
// every cycle, plus literal expectations for the documented corner cases.
module tb_multdiv32;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done;

   multdiv32 dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} computed with plain arithmetic
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      int          sa, sb;
      sa = a;
      sb = b;
      case (o)
         2'b00: p = longint'(sa) * longint'(sb);
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0)                                 p = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
            else                                            p = {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFFFFFF};
            else            p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Reference model: an accepted start produces its result 33 edges later
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [63:0] pending = '0;
   logic        m_done = 1'b0;
   int          remaining = 0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_done = 1'b0; remaining = 0;
      end else begin
         m_done = 1'b0;
         if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               {m_hi, m_lo} = pending;
               m_done = 1'b1;
            end
         end else if (start) begin
            pending   = ref_result(op, operand_a, operand_b);
            remaining = 33;
         end else begin
            if (mthi) m_hi = operand_a;
            if (mtlo) m_lo = operand_a;
         end
      end
   end

   always @(negedge clock) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", 32'(busy), 32'(remaining > 0));
      check("done", 32'(done), 32'(m_done));
   end

   // Called at a falling edge; start is seen on the following rising edge
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic wh, input logic wl);
      op = o; operand_a = a; operand_b = b; start = 1'b1; mthi = wh; mtlo = wl;
      @(negedge clock);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
   endtask

   task automatic wait_done(input bit noise, output int cyc, output int bcnt);
      cyc = 0; bcnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         if (noise) begin
            start = ($urandom_range(0, 3) == 0);
            mthi = $urandom_range(0, 1) == 1;
            mtlo = $urandom_range(0, 1) == 1;
            op = 2'($urandom_range(0, 3));
            operand_a = $urandom(); operand_b = $urandom();
         end
         @(negedge clock);
         cyc++;
      end
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
      int cyc, bcnt;
      issue(o, a, b, 1'b0, 1'b0);
      wait_done(1'b0, cyc, bcnt);
      check({name, "_latency"}, 32'(cyc), 32'd33);
      check({name, "_busy_cycles"}, 32'(bcnt), 32'd33);
      check({name, "_hi"}, hi, eh);
      check({name, "_lo"}, lo, el);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int cyc, bcnt;
      repeat (3) @(negedge clock);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      #2 reset = 1'b1;
      @(negedge clock);

      run_lit("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_lit("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run_lit("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_lit("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run_lit("divu_zero", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
      run_lit("div_zero_neg", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

      // MTLO in IDLE
      operand_a = 32'h12345678; mtlo = 1'b1;
      @(negedge clock);
      mtlo = 1'b0;
      check("mtlo_lo", lo, 32'h12345678);

      // start and mthi during a busy operation are ignored
      issue(2'b01, 32'd7, 32'd6, 1'b0, 1'b0);
      op = 2'b11; operand_a = 32'hDEADBEEF; operand_b = 32'd3; start = 1'b1; mthi = 1'b1;
      @(negedge clock);
      start = 1'b0; mthi = 1'b0;
      wait_done(1'b0, cyc, bcnt);
      check("busy_ignore_hi", hi, 32'd0);
      check("busy_ignore_lo", lo, 32'd42);

      // start wins over simultaneous mthi/mtlo
      issue(2'b11, 32'd50, 32'd7, 1'b1, 1'b1);
      wait_done(1'b0, cyc, bcnt);
      check("start_wins_hi", hi, 32'd1);
      check("start_wins_lo", lo, 32'd7);

      // reset mid-operation aborts with no result
      issue(2'b00, 32'd12345, 32'hFFFFFFB3, 1'b0, 1'b0);
      repeat (9) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      run_lit("after_reset", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);

      // randomized traffic, back-to-back, with noise on inputs while busy
      for (int i = 0; i < 60; i++) begin
         issue(2'($urandom_range(0, 3)), pick(), pick(),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         wait_done(1'b1, cyc, bcnt);
         check("rand_latency", 32'(cyc), 32'd33);
         check("rand_busy_cycles", 32'(bcnt), 32'd33);
         if ($urandom_range(0, 2) == 0) begin
            operand_a = $urandom();
            mthi = $urandom_range(0, 1) == 1;
            mtlo = $urandom_range(0, 1) == 1;
            @(negedge clock);
            mthi = 1'b0; mtlo = 1'b0;
         end
      end

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multdiv32.md
MULTDIV32 -- requirements
Module: multdiv32

Interface
Parameters: none; operand width fixed at 32.
REQ-001 SHALL expose: clock  input  1  single clock, all state on rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-003 SHALL expose: start  input  1  begin operation; sampled only in IDLE.
REQ-004 SHALL expose: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL expose: operand_a  input  32  rs value (read_data_1 of decode); multiplicand or dividend.
REQ-006 SHALL expose: operand_b  input  32  rt value (read_data_2 of decode); multiplier or divisor.
REQ-007 SHALL expose: mthi, mtlo  input  1 each  write operand_a into HI or LO.
REQ-008 SHALL expose: hi, lo  output  32 each  architectural HI/LO registers, read by MFHI/MFLO.
REQ-009 SHALL expose: busy  output  1  operation in progress.
REQ-010 SHALL expose: done  output  1  one-cycle pulse when HI/LO are updated by an operation.

Function
REQ-011 States SHALL be IDLE, CALC, FINISH.
REQ-012 IDLE with start=1 at edge k: SHALL latch op and operands, take magnitudes for signed ops, record result signs, clear 5-bit counter, and enter CALC.
REQ-013 CALC SHALL perform one radix-2 step per edge for 32 edges: shift-add for multiply, restoring subtract for divide. On the edge with counter=31 it SHALL enter FINISH.
REQ-014 FINISH SHALL apply sign fixup. On the next edge (k+33) it SHALL write hi/lo, drive done=1 for exactly the following cycle, and return to IDLE.
REQ-015 busy SHALL be 1 in CALC and FINISH, and 0 in IDLE. hi/lo SHALL hold old values until edge k+33.
REQ-016 MULT/MULTU: {hi,lo} SHALL equal the 64-bit product. For MULT, the product SHALL be negated when operand signs differ.
REQ-017 DIV/DIVU: lo SHALL hold the quotient and hi the remainder. Signed: quotient is negated if signs differ; remainder takes the dividend's sign (truncating division).
REQ-018 Divisor=0: SHALL produce lo=0xFFFFFFFF and hi=operand_a (unmodified), with the same 33-cycle latency and a done pulse.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0; no trap.
REQ-020 start while busy SHALL be ignored, with no effect on the current operation.
REQ-021 mthi/mtlo in IDLE SHALL write operand_a into hi/lo at that edge. While busy they SHALL be ignored.
REQ-022 If start and mthi/mtlo are both asserted in IDLE, start SHALL win and the mt write SHALL be dropped.
REQ-023 If mthi and mtlo are both asserted, both registers SHALL be written.
REQ-024 Back-to-back: start may be asserted in the cycle done=1 (state IDLE) and SHALL be accepted.

Reset
REQ-025 While reset=0: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal datapath cleared.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no HI/LO update and no done pulse. After release, the first edge SHALL be treated as IDLE.

Verification
REQ-027 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle k+34, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
REQ-028 MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, done on schedule.
REQ-031 mtlo 0x12345678 in IDLE -> lo=0x12345678 next cycle. During a busy operation: start and mthi are ignored and the final hi/lo match the first operation only.
REQ-032 reset=0 at cycle k+10 of a MULT -> busy=0 and hi=lo=0 immediately, and no done pulse. A new start after release completes normally in 33 cycles.
